// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch stage: fetch PC, one outstanding imem read, IF/ID handshake
// Optional feature macro: YSYX_22040931_IFU_BYPASS_EN presents a response in the cycle it arrives.
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        pc_valid,
  input  logic        if_ready,
  output logic [63:0] IF_pc,
  output logic [31:0] IF_instr
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state;
  logic [63:0] pc;
  logic [63:0] if_pc_q;
  logic [31:0] if_instr_q;
  logic        drop;
  logic        req_valid_q;
  logic        hold_valid_q;
  logic        req_fire;
  logic [63:0] target;
  logic [63:0] pc_next_seq;

  assign req_fire    = req_valid_q & imem_req_ready;
  assign target      = {redirect_pc[63:2], 2'b00};
  assign pc_next_seq = pc + 64'd4;

`ifdef YSYX_22040931_IFU_BYPASS_EN
  logic resp_hit;
  assign resp_hit = (state == S_WAIT) & imem_resp_valid & ~drop & ~redirect_valid;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_REQ;
      pc           <= RESET_PC;
      drop         <= 1'b0;
      req_valid_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      if_pc_q      <= 64'd0;
      if_instr_q   <= NOP;
    end else begin
      case (state)
        S_REQ: begin
          if (redirect_valid) pc <= target;
          if (req_fire) begin
            state       <= S_WAIT;
            req_valid_q <= 1'b0;
            drop        <= redirect_valid;
          end else begin
            req_valid_q <= 1'b1;
          end
        end
        S_WAIT: begin
          // A response meeting a redirect (or an owed drop) is the one owed; consume it
          // here rather than waiting for a second response that will never come.
          if (imem_resp_valid && (drop || redirect_valid)) begin
            if (redirect_valid) pc <= target;
            drop        <= 1'b0;
            state       <= S_REQ;
            req_valid_q <= 1'b1;
          end else if (redirect_valid) begin
            pc   <= target;
            drop <= 1'b1;
          end else if (imem_resp_valid) begin
`ifdef YSYX_22040931_IFU_BYPASS_EN
            if (if_ready) begin
              pc          <= pc_next_seq;
              state       <= S_REQ;
              req_valid_q <= 1'b1;
            end else begin
              if_pc_q      <= pc;
              if_instr_q   <= imem_resp_data;
              hold_valid_q <= 1'b1;
              state        <= S_HOLD;
            end
`else
            if_pc_q      <= pc;
            if_instr_q   <= imem_resp_data;
            hold_valid_q <= 1'b1;
            state        <= S_HOLD;
`endif
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            pc           <= target;
            hold_valid_q <= 1'b0;
            state        <= S_REQ;
            req_valid_q  <= 1'b1;
          end else if (if_ready) begin
            pc           <= pc_next_seq;
            hold_valid_q <= 1'b0;
            state        <= S_REQ;
            req_valid_q  <= 1'b1;
          end
        end
        default: begin
          state        <= S_REQ;
          hold_valid_q <= 1'b0;
          req_valid_q  <= 1'b1;
        end
      endcase
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc;

`ifdef YSYX_22040931_IFU_BYPASS_EN
  assign pc_valid = (hold_valid_q | resp_hit) & ~redirect_valid;
  assign IF_pc    = resp_hit ? pc : if_pc_q;
  assign IF_instr = resp_hit ? imem_resp_data : if_instr_q;
`else
  assign pc_valid = hold_valid_q & ~redirect_valid;
  assign IF_pc    = if_pc_q;
  assign IF_instr = if_instr_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - self-checking bench for ifu_fetch with a latency-programmable memory model
module tb_ifu_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        pc_valid;
  logic        if_ready;
  logic [63:0] IF_pc;
  logic [31:0] IF_instr;

  ifu_fetch dut (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .pc_valid(pc_valid), .if_ready(if_ready), .IF_pc(IF_pc), .IF_instr(IF_instr)
  );

  always #5 clock = ~clock;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic        if_ready;
    logic        req;
    logic [63:0] addr;
    logic        pv;
    logic [63:0] ifpc;
  } vec_t;

  exp_t        sb[$];
  vec_t        tbl[7];
  int          n_total = 0;
  int          n_pass  = 0;
  int          mem_lat = 1;
  int          pend_cnt = 0;
  logic [63:0] pend_a;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] lo;
    lo = a[31:0];
    return 32'h0010_0093 ^ (lo << 8);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic expect_xfer(input logic [63:0] pc);
    exp_t e;
    e.pc = pc;
    e.instr = mem_word(pc);
    sb.push_back(e);
  endtask

  // One clock: sample handshakes before the edge, then drive the memory response after it.
  task automatic step();
    logic        fire;
    logic        xfer;
    logic [63:0] fa;
    exp_t        e;
    #1;
    fire = (imem_req_valid & imem_req_ready) === 1'b1;
    xfer = (pc_valid & if_ready) === 1'b1;
    fa   = imem_addr;
    if (xfer) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_xfer", IF_pc, 64'hDEAD);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", IF_pc, e.pc);
        chk("sb_instr", {32'd0, IF_instr}, {32'd0, e.instr});
      end
    end
    @(posedge clock);
    #1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    if (fire) begin
      pend_cnt = mem_lat;
      pend_a   = fa;
    end
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(pend_a);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 1'b1, RST_PC,        1'b0, 64'd0};
    tbl[1] = '{1'b1, 1'b0, RST_PC,        1'b0, 64'd0};
    tbl[2] = '{1'b1, 1'b0, RST_PC,        1'b1, RST_PC};
    tbl[3] = '{1'b1, 1'b1, RST_PC + 4,    1'b0, RST_PC};
    tbl[4] = '{1'b1, 1'b0, RST_PC + 4,    1'b0, RST_PC};
    tbl[5] = '{1'b1, 1'b0, RST_PC + 4,    1'b1, RST_PC + 4};
    tbl[6] = '{1'b1, 1'b1, RST_PC + 8,    1'b0, RST_PC + 4};

    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'd0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'd0; if_ready = 1'b1;
    step(); step();
    chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("rst_pc_valid", {63'd0, pc_valid}, 64'd0);
    chk("rst_if_pc", IF_pc, 64'd0);
    chk("rst_if_instr", {32'd0, IF_instr}, 64'h13);
    reset = 1'b0;
    step();

`ifndef YSYX_22040931_IFU_BYPASS_EN
    expect_xfer(RST_PC);
    expect_xfer(RST_PC + 4);
    for (int i = 0; i < 7; i++) begin
      if_ready = tbl[i].if_ready;
      chk($sformatf("tbl%0d_req", i), {63'd0, imem_req_valid}, {63'd0, tbl[i].req});
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_pv", i), {63'd0, pc_valid}, {63'd0, tbl[i].pv});
      chk($sformatf("tbl%0d_ifpc", i), IF_pc, tbl[i].ifpc);
      step();
    end

    // HOLD stall: outputs stable, no new request
    expect_xfer(RST_PC + 8);
    if_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("stall_pv", {63'd0, pc_valid}, 64'd1);
      chk("stall_pc", IF_pc, RST_PC + 8);
      chk("stall_instr", {32'd0, IF_instr}, {32'd0, mem_word(RST_PC + 8)});
      chk("stall_req", {63'd0, imem_req_valid}, 64'd0);
      step();
    end
    if_ready = 1'b1;
    step();
    chk("stall_next_req", {63'd0, imem_req_valid}, 64'd1);
    chk("stall_next_addr", imem_addr, RST_PC + 12);

    // Redirect during WAIT drops the pending response
    mem_lat = 2;
    step();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0103;
    #1;
    chk("rdw_pv_forced", {63'd0, pc_valid}, 64'd0);
    step();
    redirect_valid = 1'b0;
    chk("rdw_resp_seen", {63'd0, imem_resp_valid}, 64'd1);
    chk("rdw_drop_pv", {63'd0, pc_valid}, 64'd0);
    step();
    chk("rdw_req", {63'd0, imem_req_valid}, 64'd1);
    chk("rdw_addr", imem_addr, 64'h8000_0100);
    mem_lat = 1;
    expect_xfer(64'h8000_0100);
    step(); step(); step();
    chk("rdw_next_addr", imem_addr, 64'h8000_0104);

    // Redirect on REQ handshake, then again while dropping
    mem_lat = 3;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
    step();
    redirect_pc = 64'h8000_0300;
    step();
    redirect_valid = 1'b0;
    chk("rr_one_outstanding", {63'd0, imem_req_valid}, 64'd0);
    step();
    chk("rr_drop_pv", {63'd0, pc_valid}, 64'd0);
    step();
    chk("rr_req", {63'd0, imem_req_valid}, 64'd1);
    chk("rr_addr", imem_addr, 64'h8000_0300);
    mem_lat = 1;
    expect_xfer(64'h8000_0300);
    step(); step(); step();
    chk("rr_next_addr", imem_addr, 64'h8000_0304);

    // PC wrap at the top of the address space
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    step();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    chk("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    expect_xfer(64'hFFFF_FFFF_FFFF_FFFC);
    step(); step(); step();
    chk("wrap_req", {63'd0, imem_req_valid}, 64'd1);
    chk("wrap_next_addr", imem_addr, 64'd0);

    // Redirect in HOLD discards the held instruction
    if_ready = 1'b0;
    step(); step();
    chk("rdh_pv", {63'd0, pc_valid}, 64'd1);
    chk("rdh_pc", IF_pc, 64'd0);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0400; if_ready = 1'b1;
    #1;
    chk("rdh_pv_forced", {63'd0, pc_valid}, 64'd0);
    step();
    redirect_valid = 1'b0;
    chk("rdh_req", {63'd0, imem_req_valid}, 64'd1);
    chk("rdh_addr", imem_addr, 64'h8000_0400);
    chk("rdh_pv_after", {63'd0, pc_valid}, 64'd0);

    // Reset in WAIT, late response must be ignored
    mem_lat = 2;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rw_resp_seen", {63'd0, imem_resp_valid}, 64'd1);
    chk("rw_req", {63'd0, imem_req_valid}, 64'd0);
    chk("rw_pv", {63'd0, pc_valid}, 64'd0);
    chk("rw_instr", {32'd0, IF_instr}, 64'h13);
    step();
    chk("rw_req_after", {63'd0, imem_req_valid}, 64'd1);
    chk("rw_addr_after", imem_addr, RST_PC);
    chk("rw_pv_after", {63'd0, pc_valid}, 64'd0);
    mem_lat = 1;
    expect_xfer(RST_PC);
    step(); step(); step();
    chk("rw_next_addr", imem_addr, RST_PC + 4);
`else
    expect_xfer(RST_PC);
    chk("byp_req", {63'd0, imem_req_valid}, 64'd1);
    chk("byp_addr", imem_addr, RST_PC);
    step();
    chk("byp_pv", {63'd0, pc_valid}, 64'd1);
    chk("byp_pc", IF_pc, RST_PC);
    chk("byp_instr", {32'd0, IF_instr}, {32'd0, mem_word(RST_PC)});
    step();
    chk("byp_next_req", {63'd0, imem_req_valid}, 64'd1);
    chk("byp_next_addr", imem_addr, RST_PC + 4);
    mem_lat = 2;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("byp_rw_pv", {63'd0, pc_valid}, 64'd0);
    step();
    chk("byp_rw_addr", imem_addr, RST_PC);
    mem_lat = 1;
    expect_xfer(RST_PC);
    step();
    chk("byp_rw_pv_resp", {63'd0, pc_valid}, 64'd1);
    step();
`endif

    chk("sb_drained", sb.size(), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch stage: holds the architectural fetch PC, issues one instruction-memory read at a time, and presents each fetched instruction with its PC to the IF/ID pipeline register through a valid/ready handshake. Sits directly upstream of the IF/ID register. Redirects from execute, such as taken branches, jumps and traps, discard any in-flight fetch and restart at the new PC.

## Interface
- `RESET_PC`, default 64'h8000_0000, first fetch address after reset.
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `redirect_valid`  in  1  redirect request from execute; same cycle as the IF/ID flush.
- `redirect_pc`  in  64  redirect target; bits [1:0] are ignored and forced to 0.
- `imem_req_valid`  out  1  read request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_addr`  out  64  request address (current fetch PC).
- `imem_resp_valid`  in  1  read data valid; one response per accepted request, 1+ cycles later.
- `imem_resp_data`  in  32  instruction word.
- `pc_valid`  out  1  `IF_pc`/`IF_instr` hold a valid instruction.
- `if_ready`  in  1  IF/ID register can accept this cycle.
- `IF_pc`  out  64  PC of presented instruction.
- `IF_instr`  out  32  presented instruction.

## Operation
- Transfer to IF/ID occurs when `pc_valid & if_ready`. Fetch-to-memory transfer occurs when `imem_req_valid & imem_req_ready`.
- FSM states:
  - REQ: `imem_req_valid=1`, `imem_addr=pc`. On handshake -> WAIT.
  - WAIT: awaiting response. On `imem_resp_valid`, latch data -> HOLD.
  - HOLD: `pc_valid=1`, outputs stable. On transfer, `pc <= pc+4` -> REQ.
- Only one request is ever outstanding; `imem_req_valid=0` outside REQ.
- PC arithmetic: 64-bit modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
- Redirect has the highest priority, and `pc <= {redirect_pc[63:2],2'b00}`.
  - REQ: if a handshake occurs in the same cycle, go to WAIT with `drop=1`. Otherwise stay in REQ at the new PC next cycle.
  - WAIT: set `drop=1` and stay in WAIT.
  - HOLD: discard the held instruction and go to REQ.
  - `pc_valid` is forced to 0 in any cycle with `redirect_valid=1`.
- `drop=1` in WAIT: the next response is consumed and discarded. Clear `drop` and go to REQ. Nothing is presented downstream.
- A redirect while `drop=1` only updates `pc`. `drop` stays 1, because exactly one response is still owed.
- `if_ready` is never required to stay stable. Outputs in HOLD remain stable until transfer or redirect.

## Timing
- Reset values: state=REQ, pc=`RESET_PC`, drop=0, `pc_valid=0`, `imem_req_valid=0`, `IF_pc=0`, `IF_instr=32'h0000_0013` (NOP).
- First cycle after reset deassertion: `imem_req_valid=1`, `imem_addr=RESET_PC`.
- Reset asserted mid-operation, including in WAIT: returns to the reset state next cycle. A response arriving afterward is ignored in REQ.
- Base latency, with a 1-cycle memory and `if_ready=1`:
  - request accepted in cycle t
  - response in t+1
  - `pc_valid` in t+2
  - next request in t+3
  - throughput 1 instruction per 3 cycles.
- `imem_resp_valid` outside WAIT is ignored.

## Configuration
- `YSYX_22040931_IFU_BYPASS_EN` defined:
  - In WAIT with `imem_resp_valid=1` and `drop=0`, `pc_valid=1`, `IF_instr=imem_resp_data` combinationally.
  - If `if_ready`, transfer and go straight to REQ at pc+4. Otherwise latch and go to HOLD.
  - Latency is response cycle = presentation cycle; throughput 1 per 2 cycles with a 1-cycle memory.
- Not defined: response always registered via HOLD, as above. Outputs are registered only.

## Test plan
- Reset, then `imem_req_ready=1` and 1-cycle memory returning `32'h0010_0093` -> `imem_addr=8000_0000`; `pc_valid` at cycle 3 with `IF_pc=8000_0000`; next request `8000_0004`.
- `if_ready=0` for 5 cycles in HOLD -> `IF_pc`/`IF_instr` stable, no new request. After `if_ready=1`, one transfer, then a request to `+4`.
- `redirect_valid` with `redirect_pc=8000_0103` during WAIT -> the pending response is dropped with no `pc_valid`; next request `imem_addr=8000_0100`.
- Redirect in the same cycle as a REQ handshake, and again while dropping -> exactly one response discarded; fetch resumes at the latest target.
- `pc=FFFF_FFFF_FFFF_FFFC` via redirect -> after transfer, next `imem_addr=0`.
- Reset asserted in WAIT, response arriving the next cycle -> response ignored; request at `RESET_PC`. With the bypass macro, check `pc_valid` in the response cycle.
